// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, instruction
// classes, state codes, select encodings and the registered control bundle.
package ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned ST_W   = 3;

  // Opcode encoding shared with the ALU
  localparam logic [OP_W-1:0] OP_NOP   = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd2;
  localparam logic [OP_W-1:0] OP_AND   = 5'd3;
  localparam logic [OP_W-1:0] OP_OR    = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd5;
  localparam logic [OP_W-1:0] OP_SLL   = 5'd6;
  localparam logic [OP_W-1:0] OP_SRL   = 5'd7;
  localparam logic [OP_W-1:0] OP_ADDI  = 5'd8;
  localparam logic [OP_W-1:0] OP_SUBI  = 5'd9;
  localparam logic [OP_W-1:0] OP_ANDI  = 5'd10;
  localparam logic [OP_W-1:0] OP_ORI   = 5'd11;
  localparam logic [OP_W-1:0] OP_XORI  = 5'd12;
  localparam logic [OP_W-1:0] OP_SLLI  = 5'd13;
  localparam logic [OP_W-1:0] OP_LOAD  = 5'd14;
  localparam logic [OP_W-1:0] OP_STORE = 5'd15;
  localparam logic [OP_W-1:0] OP_BEQ   = 5'd16;
  localparam logic [OP_W-1:0] OP_BGT   = 5'd17;
  localparam logic [OP_W-1:0] OP_BGE   = 5'd18;
  localparam logic [OP_W-1:0] OP_BLT   = 5'd19;
  localparam logic [OP_W-1:0] OP_JALR  = 5'd20;

  localparam logic [ST_W-1:0] S_FETCH  = 3'd0;
  localparam logic [ST_W-1:0] S_DECODE = 3'd1;
  localparam logic [ST_W-1:0] S_EXEC   = 3'd2;
  localparam logic [ST_W-1:0] S_MEM    = 3'd3;
  localparam logic [ST_W-1:0] S_WB     = 3'd4;
  localparam logic [ST_W-1:0] S_TRAP   = 3'd5;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_ALU    = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC1 = 2'b10;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_RTYPE, CLS_ITYPE, CLS_LOAD,
    CLS_STORE, CLS_BRANCH, CLS_JALR, CLS_ILLEGAL
  } op_class_e;

  typedef struct packed {
    op_class_e       cls;
    logic [OP_W-1:0] alu_op;
    logic            src_imm;
  } decode_t;

  // Registered control bundle; br_exec/st_mem qualify the two input-dependent terms
  typedef struct packed {
    logic            instr_ready;
    logic [OP_W-1:0] alu_control;
    logic            alu_src_imm;
    logic            alu_out_en;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic [1:0]      wb_sel;
    logic            pc_write;
    logic [1:0]      pc_src;
    logic            br_exec;
    logic            st_mem;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: instruction class, ALU op and B-operand select.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output decode_t         dec_c
);

  always_comb begin
    dec_c.cls     = CLS_ILLEGAL;
    dec_c.alu_op  = opcode;
    dec_c.src_imm = 1'b0;
    case (opcode)
      OP_NOP: dec_c.cls = CLS_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL:
        dec_c.cls = CLS_RTYPE;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI: begin
        dec_c.cls     = CLS_ITYPE;
        dec_c.src_imm = 1'b1;
      end
      OP_LOAD: begin
        dec_c.cls     = CLS_LOAD;
        dec_c.src_imm = 1'b1;
      end
      OP_STORE: begin
        dec_c.cls     = CLS_STORE;
        dec_c.src_imm = 1'b1;
      end
      OP_BEQ, OP_BGT, OP_BGE, OP_BLT: dec_c.cls = CLS_BRANCH;
      // JALR computes rs1 + imm on the ALU adder
      OP_JALR: begin
        dec_c.cls     = CLS_JALR;
        dec_c.alu_op  = OP_ADD;
        dec_c.src_imm = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, IR latch,
// sticky illegal flag and retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  output logic              instr_ready,
  input  logic              branch_gate,
  input  logic              mem_ready,
  output logic [OP_W-1:0]   alu_control,
  output logic              alu_src_imm,
  output logic              alu_out_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic [1:0]        wb_sel,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic [REG_W-1:0]  ir_rd,
  output logic [REG_W-1:0]  ir_rs1,
  output logic [REG_W-1:0]  ir_rs2,
  output logic              illegal,
  output logic [DATA_W-1:0] instr_count
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  op_class_e         cls_q;
  decode_t           dec_c;
  ctrl_t             out_q, out_d;
  logic              retire_c;
  logic              illegal_q;
  logic [DATA_W-1:0] count_q;

  // Decode the next IR so outputs can be registered for the state being entered
  ctrl_decode u_decode (
    .opcode (ir_d[DATA_W-1 -: OP_W]),
    .dec_c  (dec_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      cls_q     <= CLS_NOP;
      out_q     <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cls_q   <= dec_c.cls;
      out_q   <= out_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
      if (retire_c) count_q <= count_q + DATA_W'(1);
    end
  end

  // Next-state and retire decision
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (instr_valid && out_q.instr_ready) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls_q)
          CLS_ILLEGAL: state_d = S_TRAP;
          CLS_NOP: begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          CLS_BRANCH: begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls_q == CLS_STORE) begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Control decode for the state being entered
  always_comb begin
    out_d = '0;
    case (state_d)
      S_FETCH:  out_d.instr_ready = 1'b1;
      S_DECODE: out_d.pc_write = (dec_c.cls == CLS_NOP);
      S_EXEC: begin
        out_d.alu_control = dec_c.alu_op;
        out_d.alu_src_imm = dec_c.src_imm;
        out_d.alu_out_en  = 1'b1;
        out_d.pc_write    = (dec_c.cls == CLS_BRANCH);
        out_d.br_exec     = (dec_c.cls == CLS_BRANCH);
      end
      S_MEM: begin
        out_d.mem_read  = (dec_c.cls == CLS_LOAD);
        out_d.mem_write = (dec_c.cls == CLS_STORE);
        out_d.st_mem    = (dec_c.cls == CLS_STORE);
      end
      S_WB: begin
        out_d.reg_write = 1'b1;
        out_d.pc_write  = 1'b1;
        case (dec_c.cls)
          CLS_LOAD: out_d.wb_sel = WB_MEM;
          CLS_JALR: begin
            out_d.wb_sel = WB_PC1;
            out_d.pc_src = PC_SRC_ALU;
          end
          default: out_d.wb_sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

  assign instr_ready = out_q.instr_ready;
  assign alu_control = out_q.alu_control;
  assign alu_src_imm = out_q.alu_src_imm;
  assign alu_out_en  = out_q.alu_out_en;
  assign mem_read    = out_q.mem_read;
  assign mem_write   = out_q.mem_write;
  assign reg_write   = out_q.reg_write;
  assign wb_sel      = out_q.wb_sel;
  // Branch outcome and store completion are only known within their own cycle
  assign pc_write    = out_q.pc_write | (out_q.st_mem & mem_ready);
  assign pc_src      = out_q.pc_src |
                       ((out_q.br_exec && branch_gate) ? PC_SRC_BRANCH : PC_SRC_SEQ);
  assign ir_rd       = ir_q[10:8];
  assign ir_rs1      = ir_q[7:5];
  assign ir_rs2      = ir_q[2:0];
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule
